sobel_scan_ctrl: RTL and testbench
==================================

// Module: sobel_scan_ctrl
// PURPOSE
//  Frame sequencer for the Sobel datapath. On start it raster-scans a 32x32 12-bit image held
//  in single-port pixel memory and fetches each 3x3 neighbourhood, one read per cycle.
//  It accumulates Gx/Gy and presents one result per pixel on a valid/ready output channel.
//  It sits between the pixel memory (memOp-style read port) and the gradient/magnitude stage.
// PARAMETERS
//  IMG_W   32  image width in pixels (>=3)
//  IMG_H   32  image height in pixels (>=3)
//  ADDR_W  10  pixel address width; IMG_W*IMG_H <= 2**ADDR_W
//  DATA_W  12  unsigned pixel width
// PORTS
//  clk          in   1         rising-edge clock
//  rst          in   1         reset, synchronous, active-high
//  start        in   1         1-cycle request to scan a frame; honoured only in IDLE
//  busy         out  1         high from the cycle after start is accepted until done
//  done         out  1         1-cycle pulse after the last result handshake
//  mem_rd_en    out  1         pixel memory read strobe
//  mem_rd_addr  out  ADDR_W    read address = row*IMG_W+col; 0 when mem_rd_en low
//  mem_rd_data  in   DATA_W    read data, valid exactly 1 cycle after mem_rd_en
//  res_valid    out  1         result available
//  res_ready    in   1         consumer accepts; transfer when res_valid & res_ready
//  res_addr     out  ADDR_W    raster address of the centre pixel for this result
//  res_gx       out  DATA_W+4  signed Gx, two's complement
//  res_gy       out  DATA_W+4  signed Gy, two's complement
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, mem_rd_en, res_valid = 0; mem_rd_addr, res_addr, res_gx,
//   res_gy, row/col counters and accumulators = 0. rst mid-frame aborts immediately: no done
//   pulse, and no further reads or results.
//  States: IDLE, FETCH, DRAIN, EMIT, FIN.
//   IDLE : start=1 -> row=col=0, busy=1; border pixel -> EMIT, else -> FETCH. start ignored
//          in every other state.
//   FETCH: 9 cycles, tap k=0..8 in row-major order (dr,dc)=(-1,-1)..(+1,+1).
//          mem_rd_en=1, addr=(row+dr)*IMG_W+(col+dc). Accumulators cleared on tap 0.
//   DRAIN: 1 cycle; the tap-8 data arrives and is accumulated -> EMIT.
//   EMIT : res_valid=1; res_addr/gx/gy stable while res_ready=0; no reads are issued.
//          On handshake: last pixel -> FIN; else advance col (wrap to 0 and row+1 at
//          IMG_W-1), then next pixel border -> EMIT, interior -> FETCH.
//   FIN  : done=1 for 1 cycle, busy=0 -> IDLE.
//  Kernels (applied to the data returned for tap k, one cycle after issue):
//   Gx=[-1 0 1;-2 0 2;-1 0 1], Gy=[-1 -2 -1;0 0 0;1 2 1].
//   Accumulate in DATA_W+4 signed; |G| <= 4*(2**DATA_W-1) = 16380, so no overflow and no
//   saturation is needed.
//  Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1): no memory reads;
//   res_gx=res_gy=0; EMIT is entered directly.
//  Timing with res_ready held high: interior pixel = 11 cycles (9 FETCH + DRAIN + EMIT);
//   border pixel = 1 cycle. Full frame (900 interior + 124 border) = 10024 cycles from the
//   first FETCH/EMIT to the last handshake; done follows 1 cycle later.
//  Results leave strictly in raster order 0..IMG_W*IMG_H-1, each address exactly once.
//  mem_rd_en is never high outside FETCH; at most one read per cycle.
// TESTING
//  T1 all-zero image, ready=1, start pulse -> 1024 results, all gx=gy=0, res_addr 0..1023
//     in order; done 1 cycle after addr 1023 handshake; busy high exactly 10025 cycles.
//  T2 vertical edge: cols 0-15=0, cols 16-31=4095 -> interior col 15 and col 16 give
//     gx=16380, gy=0; cols 14 and 17 give gx=0; border cols give 0.
//  T3 horizontal ramp: pixel=row -> every interior result gx=0, gy=8; row 0/31 give 0.
//  T4 backpressure: res_ready low for 5 cycles at addr 33 -> res_valid, res_addr=33 and
//     gx/gy held, mem_rd_en=0 throughout; on release, next read addr=1 (tap 0 of pixel 34).
//  T5 start pulsed again while busy -> ignored; exactly 1024 results and one done.
//  T6 rst asserted at the 5th FETCH cycle of pixel 40 -> next cycle all outputs 0, IDLE;
//     a new start rescans from addr 0 with correct results.

Source files
------------

// File: rtl/sobel_scan_ctrl.sv
// sobel_scan_ctrl: raster-scans an IMG_W x IMG_H frame, fetches each 3x3 window and emits Sobel Gx/Gy per pixel.
// Latency: interior pixel 11 cycles (9 reads + drain + emit), border pixel 1 cycle, with res_ready held high.
// Backpressure: EMIT holds res_addr/res_gx/res_gy stable and issues no memory reads while res_ready is low.
module sobel_scan_ctrl #(
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_rd_addr,
  input  logic [DATA_W-1:0]        mem_rd_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [ADDR_W-1:0]        res_addr,
  output logic signed [DATA_W+3:0] res_gx,
  output logic signed [DATA_W+3:0] res_gy
);

  localparam int G_W   = DATA_W + 4;
  localparam int ROW_W = $clog2(IMG_H);
  localparam int COL_W = $clog2(IMG_W);

  localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, EMIT, FIN} state_t;

  state_t                  state;
  logic [ROW_W-1:0]        row;
  logic [COL_W-1:0]        col;
  logic [ADDR_W-1:0]       pix_addr;   // row*IMG_W+col, tracked incrementally
  logic [3:0]              tap;
  logic signed [G_W-1:0]   acc_gx;
  logic signed [G_W-1:0]   acc_gy;

  logic [ROW_W-1:0]        nxt_row;
  logic [COL_W-1:0]        nxt_col;
  logic [ADDR_W-1:0]       nxt_addr;
  logic                    nxt_border;
  logic                    last_pix;

  logic [3:0]              ret_tap;
  logic signed [G_W-1:0]   pix;
  logic signed [G_W-1:0]   pix2;
  logic signed [G_W-1:0]   term_gx;
  logic signed [G_W-1:0]   term_gy;

  // Address of window tap k around centre address ctr (taps in row-major order).
  // Only used for interior pixels, so the modular arithmetic never wraps.
  function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] ctr, input logic [3:0] k);
    logic [ADDR_W-1:0] a;
    case (k)
      4'd0, 4'd1, 4'd2: a = ctr - ROW_STEP;
      4'd6, 4'd7, 4'd8: a = ctr + ROW_STEP;
      default:          a = ctr;
    endcase
    case (k)
      4'd0, 4'd3, 4'd6: a = a - ONE_A;
      4'd2, 4'd5, 4'd8: a = a + ONE_A;
      default:          ;
    endcase
    return a;
  endfunction

  // Next raster position and its classification, plus end-of-frame detection
  always_comb begin
    nxt_col    = (col == COL_LAST) ? '0 : col + 1'b1;
    nxt_row    = (col == COL_LAST) ? row + 1'b1 : row;
    nxt_addr   = pix_addr + ONE_A;
    nxt_border = (nxt_row == '0) || (nxt_row == ROW_LAST) ||
                 (nxt_col == '0) || (nxt_col == COL_LAST);
    last_pix   = (row == ROW_LAST) && (col == COL_LAST);
  end

  // Kernel weights applied to the word returning from the previous cycle's read
  always_comb begin
    ret_tap = (state == DRAIN) ? 4'd8 : tap - 4'd1;
    pix     = $signed({4'b0000, mem_rd_data});
    pix2    = pix <<< 1;
    term_gx = '0;
    term_gy = '0;
    case (ret_tap)
      4'd0: begin term_gx = -pix;  term_gy = -pix;  end
      4'd1: begin                  term_gy = -pix2; end
      4'd2: begin term_gx = pix;   term_gy = -pix;  end
      4'd3: begin term_gx = -pix2;                  end
      4'd5: begin term_gx = pix2;                   end
      4'd6: begin term_gx = -pix;  term_gy = pix;   end
      4'd7: begin                  term_gy = pix2;  end
      4'd8: begin term_gx = pix;   term_gy = pix;   end
      default: ;
    endcase
  end

  // Frame sequencer: scan position, window fetch, accumulation and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      row         <= '0;
      col         <= '0;
      pix_addr    <= '0;
      tap         <= '0;
      acc_gx      <= '0;
      acc_gy      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      res_valid   <= 1'b0;
      res_addr    <= '0;
      res_gx      <= '0;
      res_gy      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row       <= '0;
            col       <= '0;
            pix_addr  <= '0;
            busy      <= 1'b1;
            // the raster origin is always a border pixel
            state     <= EMIT;
            res_valid <= 1'b1;
            res_addr  <= '0;
            res_gx    <= '0;
            res_gy    <= '0;
          end
        end

        FETCH: begin
          if (tap == 4'd0) begin
            acc_gx <= '0;
            acc_gy <= '0;
          end else begin
            acc_gx <= acc_gx + term_gx;
            acc_gy <= acc_gy + term_gy;
          end
          if (tap == 4'd8) begin
            state       <= DRAIN;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
          end else begin
            tap         <= tap + 4'd1;
            mem_rd_addr <= tap_addr(pix_addr, tap + 4'd1);
          end
        end

        DRAIN: begin
          res_gx    <= acc_gx + term_gx;
          res_gy    <= acc_gy + term_gy;
          res_addr  <= pix_addr;
          res_valid <= 1'b1;
          state     <= EMIT;
        end

        EMIT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (last_pix) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              row      <= nxt_row;
              col      <= nxt_col;
              pix_addr <= nxt_addr;
              if (nxt_border) begin
                res_valid <= 1'b1;
                res_addr  <= nxt_addr;
                res_gx    <= '0;
                res_gy    <= '0;
              end else begin
                state       <= FETCH;
                tap         <= '0;
                mem_rd_en   <= 1'b1;
                mem_rd_addr <= tap_addr(nxt_addr, 4'd0);
              end
            end
          end
        end

        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_scan_ctrl.sv
// tb_sobel_scan_ctrl: drives full frames through sobel_scan_ctrl against a behavioural Sobel model.
// Latency: not applicable (bench).
// Backpressure: res_ready driven always-high, randomly, or held low around one result.
module tb_sobel_scan_ctrl;

  localparam int W    = 32;
  localparam int H    = 32;
  localparam int AW   = 10;
  localparam int DW   = 12;
  localparam int GW   = DW + 4;
  localparam int NPIX = W * H;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 res_ready;
  logic                 busy;
  logic                 done;
  logic                 mem_rd_en;
  logic [AW-1:0]        mem_rd_addr;
  logic [DW-1:0]        mem_rd_data;
  logic                 res_valid;
  logic [AW-1:0]        res_addr;
  logic signed [GW-1:0] res_gx;
  logic signed [GW-1:0] res_gy;

  logic [DW-1:0] img [NPIX];

  int errors = 0;
  int checks = 0;
  int cyc_n = 0;
  int exp_idx, res_cnt, done_cnt, busy_cnt, rd_viol, hs_last_cyc, done_cyc;
  int seen_gx [NPIX];
  int seen_gy [NPIX];

  typedef struct {
    int pat;
    int addr;
    int gx;
    int gy;
  } vec_t;
  vec_t vecs [12];

  always #5 clk = ~clk;

  sobel_scan_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_addr    (res_addr),
    .res_gx      (res_gx),
    .res_gy      (res_gy)
  );

  // Single-port pixel memory: data returns one cycle after the read strobe
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= img[mem_rd_addr];
  end

  function automatic void chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Sobel reference straight from the kernel definition; borders give zero
  function automatic void model(input int a, output int gx, output int gy);
    int r, c, p;
    r  = a / W;
    c  = a % W;
    gx = 0;
    gy = 0;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        p  = int'(img[(r + dr) * W + (c + dc)]);
        gx += dc * ((dr == 0) ? 2 : 1) * p;
        gy += dr * ((dc == 0) ? 2 : 1) * p;
      end
    end
  endfunction

  // Scoreboard: observe outputs on the falling edge, check each transfer against the model
  always @(negedge clk) begin
    int mgx, mgy;
    cyc_n++;
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc_n;
    end
    if ((mem_rd_en && (res_valid || !busy)) || (!mem_rd_en && mem_rd_addr != '0)) rd_viol++;
    if (!rst && res_valid && res_ready) begin
      model(int'(res_addr), mgx, mgy);
      chk("res_addr_order", res_addr, exp_idx);
      chk("res_gx", res_gx, mgx);
      chk("res_gy", res_gy, mgy);
      seen_gx[res_addr] = int'(res_gx);
      seen_gy[res_addr] = int'(res_gy);
      exp_idx++;
      res_cnt++;
      hs_last_cyc = cyc_n;
    end
  end

  task automatic sb_clear();
    exp_idx     = 0;
    res_cnt     = 0;
    done_cnt    = 0;
    busy_cnt    = 0;
    rd_viol     = 0;
    hs_last_cyc = -1;
    done_cyc    = -1;
    for (int i = 0; i < NPIX; i++) begin
      seen_gx[i] = -99999;
      seen_gy[i] = -99999;
    end
  endtask

  task automatic fill_img(input int pat);
    for (int i = 0; i < NPIX; i++) begin
      case (pat)
        0:       img[i] = '0;
        1:       img[i] = ((i % W) >= 16) ? 12'd4095 : 12'd0;
        2:       img[i] = DW'(i / W);
        default: img[i] = DW'($urandom_range(0, 4095));
      endcase
    end
  endtask

  task automatic chk_idle_outputs();
    chk("idle_busy",      busy,        0);
    chk("idle_done",      done,        0);
    chk("idle_rd_en",     mem_rd_en,   0);
    chk("idle_rd_addr",   mem_rd_addr, 0);
    chk("idle_res_valid", res_valid,   0);
    chk("idle_res_addr",  res_addr,    0);
    chk("idle_res_gx",    res_gx,      0);
    chk("idle_res_gy",    res_gy,      0);
  endtask

  // rmode 0: ready always high; 1: random ready plus stray start pulses; 2: hold ready low at addr 33
  task automatic run_frame(input int rmode);
    int cyc, mgx, mgy;
    bit held;
    logic signed [GW-1:0] hgx, hgy;
    sb_clear();
    held      = 1'b0;
    res_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 0;
    while (done_cnt == 0 && cyc < 30000) begin
      start = 1'b0;
      if (rmode == 1) begin
        res_ready = ($urandom_range(0, 3) != 0);
        if (cyc == 50 || cyc == 4000) start = 1'b1;
      end else begin
        res_ready = 1'b1;
      end
      if (rmode == 2 && !held && res_valid && res_addr == 33) begin
        held      = 1'b1;
        hgx       = res_gx;
        hgy       = res_gy;
        res_ready = 1'b0;
        model(33, mgx, mgy);
        chk("bp_gx_value", hgx, mgx);
        chk("bp_gy_value", hgy, mgy);
        for (int i = 0; i < 5; i++) begin
          @(posedge clk); #1;
          chk("bp_valid_held", res_valid, 1);
          chk("bp_addr_held",  res_addr,  33);
          chk("bp_gx_held",    res_gx,    hgx);
          chk("bp_gy_held",    res_gy,    hgy);
          chk("bp_no_read",    mem_rd_en, 0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_next_rd_en",   mem_rd_en,   1);
        chk("bp_next_rd_addr", mem_rd_addr, 1);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("frame_done_seen", done_cnt > 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("result_count",       res_cnt,  NPIX);
    chk("done_count",         done_cnt, 1);
    chk("busy_after_frame",   busy,     0);
    chk("done_after_last_hs", done_cyc, hs_last_cyc + 1);
    chk("read_protocol",      rd_viol,  0);
    if (rmode == 0) chk("busy_cycles", busy_cnt, 10025);
    if (rmode == 2) chk("bp_hold_seen", held, 1);
  endtask

  task automatic check_vectors(input int pat);
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].pat == pat) begin
        chk("vec_gx", seen_gx[vecs[i].addr], vecs[i].gx);
        chk("vec_gy", seen_gy[vecs[i].addr], vecs[i].gy);
      end
    end
  endtask

  initial begin
    int cyc;
    // pattern 1: vertical edge at col 16; pattern 2: ramp pixel=row
    vecs[0]  = '{1,  1 * W + 15, 16380, 0};
    vecs[1]  = '{1,  5 * W + 16, 16380, 0};
    vecs[2]  = '{1, 30 * W + 15, 16380, 0};
    vecs[3]  = '{1,  5 * W + 14,     0, 0};
    vecs[4]  = '{1,  5 * W + 17,     0, 0};
    vecs[5]  = '{1,  0 * W + 16,     0, 0};
    vecs[6]  = '{1,  7 * W + 31,     0, 0};
    vecs[7]  = '{2, 10 * W + 10,     0, 8};
    vecs[8]  = '{2, 30 * W + 30,     0, 8};
    vecs[9]  = '{2,  1 * W +  1,     0, 8};
    vecs[10] = '{2,  0 * W +  5,     0, 0};
    vecs[11] = '{2, 31 * W +  5,     0, 0};

    rst       = 1'b1;
    start     = 1'b0;
    res_ready = 1'b0;
    fill_img(0);
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs();
    rst = 1'b0;
    @(posedge clk); #1;

    // all-zero image, exact frame timing
    fill_img(0);
    run_frame(0);

    // vertical edge
    fill_img(1);
    run_frame(0);
    check_vectors(1);

    // ramp with backpressure at addr 33
    fill_img(2);
    run_frame(2);
    check_vectors(2);

    // random image, random ready, stray starts while busy
    fill_img(3);
    run_frame(1);

    // abort at the 5th read of pixel 40, then rescan
    fill_img(3);
    sb_clear();
    res_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 0;
    while (res_cnt < 40 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("abort_reached_pixel40", res_cnt, 40);
    repeat (4) @(posedge clk);
    #1;
    chk("abort_tap4_rd_en",   mem_rd_en,   1);
    chk("abort_tap4_rd_addr", mem_rd_addr, 40);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_idle_outputs();
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done",    done_cnt,  0);
    chk("abort_no_results", res_cnt,   40);
    chk("abort_no_reads",   mem_rd_en, 0);
    chk("abort_stays_idle", busy,      0);
    run_frame(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
